// File: rtl/filter_spad_pkg.sv
// Shared constants, FSM state type and address helper for the filter
// scratchpad controller.
package filter_spad_pkg;

  localparam int SPAD_DEPTH  = 224;
  localparam int SPAD_ADDR_W = 8;
  localparam int SPAD_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    LDONE = 2'd2
  } fspad_state_e;

  // Advance a scratchpad address by one, wrapping from depth-1 back to 0.
  function automatic logic [SPAD_ADDR_W-1:0] wrap_inc(
    input logic [SPAD_ADDR_W-1:0] a,
    input int                     depth
  );
    if ({1'b0, a} >= 9'(depth - 1)) return '0;
    return a + 8'd1;
  endfunction

endpackage

// File: rtl/filter_spad_ctrl_arb.sv
// fspad_arb: per-cycle grant between PE reads and load writes on the shared
// single-port scratchpad bus.
// Build option FILTER_SPAD_CTRL_RR_EN selects round-robin arbitration;
// without it reads always win and writes can starve under continuous reads.
// In both modes a write is never granted in the cycle after a read grant,
// because the scratchpad is driving the data bus in that cycle.
module fspad_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_req,   // in-range read request, already reset-gated
  input  logic wr_req,   // write pending (LOAD & ld_valid), already reset-gated
  output logic rd_gnt,
  output logic wr_gnt
);

  // High in the cycle after a read grant: spad owns the bus.
  logic turn_q;

`ifdef FILTER_SPAD_CTRL_RR_EN
  // bubble_q: read was granted while a write waited, so hold off both sides.
  // wprio_q:  bubble just elapsed, the waiting write now beats any read.
  logic bubble_q;
  logic wprio_q;

  // Round-robin grant selection
  always_comb begin
    rd_gnt = 1'b0;
    wr_gnt = 1'b0;
    if (!bubble_q) begin
      if (wprio_q && wr_req) begin
        wr_gnt = 1'b1;
      end else begin
        rd_gnt = rd_req;
        wr_gnt = wr_req & ~rd_req & ~turn_q;
      end
    end
  end

  // Round-robin sequencing state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bubble_q <= 1'b0;
      wprio_q  <= 1'b0;
    end else begin
      bubble_q <= rd_gnt & wr_req;
      wprio_q  <= bubble_q;
    end
  end
`else
  // Fixed priority: reads first, writes only on a free, non-turnaround cycle
  always_comb begin
    rd_gnt = rd_req;
    wr_gnt = wr_req & ~rd_req & ~turn_q;
  end
`endif

  // Bus turnaround tracking
  always_ff @(posedge clk) begin
    if (!rst_n) turn_q <= 1'b0;
    else        turn_q <= rd_gnt;
  end

endmodule

// File: rtl/filter_spad_ctrl.sv
// filter_spad_ctrl: burst loader and PE read port for an external 224x16
// registered-read filter scratchpad sharing one tristate data bus.
// Build option FILTER_SPAD_CTRL_RR_EN (consumed by fspad_arb) switches the
// read/write arbitration from fixed read priority to round-robin.
module filter_spad_ctrl
  import filter_spad_pkg::*;
#(
  parameter int DEPTH  = SPAD_DEPTH,
  parameter int DATA_W = SPAD_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ld_start,
  input  logic [SPAD_ADDR_W-1:0] ld_base,
  input  logic [SPAD_ADDR_W-1:0] ld_len,
  input  logic                   ld_valid,
  input  logic [DATA_W-1:0]      ld_data,
  output logic                   ld_ready,
  output logic                   ld_busy,
  output logic                   ld_done,
  input  logic                   rd_req,
  input  logic [SPAD_ADDR_W-1:0] rd_addr,
  output logic                   rd_gnt,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_err,
  output logic [SPAD_ADDR_W-1:0] spad_addr,
  output logic                   spad_we,
  inout  wire  [DATA_W-1:0]      spad_data
);

  localparam logic [SPAD_ADDR_W:0] DEPTH_C = 9'(DEPTH);

  fspad_state_e state_q, state_d;

  logic [SPAD_ADDR_W-1:0] ptr_q, ptr_d;     // next write address
  logic [SPAD_ADDR_W:0]   cnt_q, cnt_d;     // words accepted this burst
  logic [SPAD_ADDR_W:0]   len_q, len_d;     // clamped burst length
  logic [SPAD_ADDR_W-1:0] addr_q;           // last driven spad address
  logic                   rd_valid_q;
  logic                   rd_err_q;

  logic                   rd_in_rng;
  logic                   rd_ok;
  logic                   rd_oor;
  logic                   wr_req;
  logic                   wr_gnt;
  logic [SPAD_ADDR_W:0]   len_clamp;
  logic [SPAD_ADDR_W-1:0] base_wrap;

  // Request qualification; everything is held off while reset is asserted
  // so the bus is quiet even if the FSM was mid-burst at the reset edge.
  assign rd_in_rng = ({1'b0, rd_addr} < DEPTH_C);
  assign rd_ok     = rst_n & rd_req & rd_in_rng;
  assign rd_oor    = rst_n & rd_req & ~rd_in_rng;
  assign wr_req    = rst_n & (state_q == LOAD) & ld_valid;

  // Oversized bursts are clamped to one full pass of the scratchpad, and an
  // out-of-range base is folded back into the address space.
  assign len_clamp = ({1'b0, ld_len} > DEPTH_C) ? DEPTH_C : {1'b0, ld_len};
  assign base_wrap = ({1'b0, ld_base} >= DEPTH_C) ?
                     SPAD_ADDR_W'({1'b0, ld_base} - DEPTH_C) : ld_base;

  fspad_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_req (rd_ok),
    .wr_req (wr_req),
    .rd_gnt (rd_gnt),
    .wr_gnt (wr_gnt)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; ld_start is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ld_start) state_d = (ld_len == '0) ? LDONE : LOAD;
      LOAD:    if (wr_gnt && ((cnt_q + 9'd1) == len_q)) state_d = LDONE;
      LDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    ld_busy  = rst_n & (state_q != IDLE);
    ld_done  = rst_n & (state_q == LDONE);
    ld_ready = wr_gnt;
  end

  // Burst datapath next-state: latch on start, advance on each accepted word
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    len_d = len_q;
    if ((state_q == IDLE) && ld_start) begin
      ptr_d = base_wrap;
      cnt_d = '0;
      len_d = len_clamp;
    end else if (wr_gnt) begin
      ptr_d = wrap_inc(ptr_q, DEPTH);
      cnt_d = cnt_q + 9'd1;
    end
  end

  // Burst datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
    end
  end

  // Scratchpad port: address follows this cycle's grant, otherwise holds.
  assign spad_we   = wr_gnt;
  assign spad_addr = rd_gnt ? rd_addr :
                     wr_gnt ? ptr_q   :
                     (rst_n ? addr_q : '0);
  assign spad_data = spad_we ? ld_data : 'z;

  // Held address and read-response tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      addr_q     <= spad_addr;
      rd_valid_q <= rd_gnt;
      rd_err_q   <= rd_oor;
    end
  end

  // Registered-read spad returns data on the bus the cycle after the grant.
  assign rd_valid = rst_n & rd_valid_q;
  assign rd_err   = rst_n & rd_err_q;
  assign rd_data  = rd_valid ? spad_data : '0;

endmodule

// File: tb/tb_filter_spad_ctrl.sv
// Directed bench for filter_spad_ctrl with a 224x16 registered-read
// scratchpad model on the shared tristate bus.
module tb_filter_spad_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ld_start;
  logic [7:0]  ld_base;
  logic [7:0]  ld_len;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_err;
  logic [7:0]  spad_addr;
  logic        spad_we;
  wire  [15:0] spad_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  filter_spad_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .spad_addr(spad_addr), .spad_we(spad_we), .spad_data(spad_data)
  );

  // Scratchpad model: synchronous write, registered read driven next cycle
  logic [15:0] mem [0:223] = '{default: 16'h0};
  logic [15:0] rdq = 16'h0;
  logic        oe_q = 1'b0;

  always @(posedge clk) begin
    oe_q <= rd_gnt;
    if (spad_addr < 8'd224) begin
      if (spad_we)     mem[spad_addr] <= spad_data;
      else if (rd_gnt) rdq <= mem[spad_addr];
    end
  end
  assign spad_data = oe_q ? rdq : 16'hzzzz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int  nw;
    bit  done;
    bit  prev_rd;
    bit  exp_rd;
    bit  exp_wr;

    rst_n = 1'b0; ld_start = 1'b0; ld_base = '0; ld_len = '0;
    ld_valid = 1'b0; ld_data = '0; rd_req = 1'b0; rd_addr = '0;

    // ---- reset state, with a read request attempted during reset
    tick(); tick();
    rd_req = 1'b1; rd_addr = 8'h05;
    mid();
    chk("rst_ld_ready", 32'(ld_ready), 32'(0));
    chk("rst_ld_busy",  32'(ld_busy),  32'(0));
    chk("rst_ld_done",  32'(ld_done),  32'(0));
    chk("rst_rd_gnt",   32'(rd_gnt),   32'(0));
    chk("rst_rd_valid", 32'(rd_valid), 32'(0));
    chk("rst_rd_err",   32'(rd_err),   32'(0));
    chk("rst_spad_we",  32'(spad_we),  32'(0));
    chk("rst_spad_addr", 32'(spad_addr), 32'(0));
    chk("rst_rd_data",  32'(rd_data),  32'(0));
    tick();
    rd_req = 1'b0; rst_n = 1'b1;
    tick();

    // ---- load base 0x10 len 4
    ld_start = 1'b1; ld_base = 8'h10; ld_len = 8'd4;
    mid();
    chk("l1_idle_busy", 32'(ld_busy), 32'(0));
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 16'(16'hA001 + i);
      mid();
      chk($sformatf("l1_ready%0d", i), 32'(ld_ready), 32'(1));
      chk($sformatf("l1_we%0d", i),    32'(spad_we), 32'(1));
      chk($sformatf("l1_addr%0d", i),  32'(spad_addr), 32'(8'h10 + i));
      chk($sformatf("l1_bus%0d", i),   32'(spad_data), 32'(16'hA001 + i));
      chk($sformatf("l1_busy%0d", i),  32'(ld_busy), 32'(1));
      chk($sformatf("l1_done%0d", i),  32'(ld_done), 32'(0));
      tick();
    end
    ld_valid = 1'b0;
    mid();
    chk("l1_done",      32'(ld_done), 32'(1));
    chk("l1_done_busy", 32'(ld_busy), 32'(1));
    chk("l1_done_rdy",  32'(ld_ready), 32'(0));
    chk("l1_done_we",   32'(spad_we), 32'(0));
    chk("l1_hold_addr", 32'(spad_addr), 32'(8'h13));
    tick();
    mid();
    chk("l1_done_clr", 32'(ld_done), 32'(0));
    chk("l1_idle",     32'(ld_busy), 32'(0));
    for (int i = 0; i < 4; i++) chk($sformatf("l1_mem%0d", i), 32'(mem[8'h10 + i]), 32'(16'hA001 + i));
    tick();

    // ---- load across the wrap point: base 222 len 4
    ld_start = 1'b1; ld_base = 8'd222; ld_len = 8'd4;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 16'(16'hB001 + i);
      mid();
      chk($sformatf("l2_addr%0d", i), 32'(spad_addr), 32'((222 + i) % 224));
      tick();
    end
    ld_valid = 1'b0;
    mid();
    chk("l2_done", 32'(ld_done), 32'(1));
    tick();
    chk("l2_mem222", 32'(mem[222]), 32'(16'hB001));
    chk("l2_mem223", 32'(mem[223]), 32'(16'hB002));
    chk("l2_mem0",   32'(mem[0]),   32'(16'hB003));
    chk("l2_mem1",   32'(mem[1]),   32'(16'hB004));

    // ---- back-to-back reads at 0x10, 0x11
    rd_req = 1'b1; rd_addr = 8'h10;
    mid();
    chk("r1_gnt",   32'(rd_gnt), 32'(1));
    chk("r1_addr",  32'(spad_addr), 32'(8'h10));
    chk("r1_we",    32'(spad_we), 32'(0));
    chk("r1_valid", 32'(rd_valid), 32'(0));
    tick();
    rd_addr = 8'h11;
    mid();
    chk("r2_gnt",   32'(rd_gnt), 32'(1));
    chk("r2_valid", 32'(rd_valid), 32'(1));
    chk("r2_data",  32'(rd_data), 32'(16'hA001));
    tick();
    rd_req = 1'b0;
    mid();
    chk("r3_gnt",   32'(rd_gnt), 32'(0));
    chk("r3_valid", 32'(rd_valid), 32'(1));
    chk("r3_data",  32'(rd_data), 32'(16'hA002));
    chk("r3_hold",  32'(spad_addr), 32'(8'h11));
    tick();
    mid();
    chk("r4_valid", 32'(rd_valid), 32'(0));
    chk("r4_data",  32'(rd_data), 32'(0));
    tick();

    // ---- out-of-range read
    rd_req = 1'b1; rd_addr = 8'd224;
    mid();
    chk("oor_gnt",  32'(rd_gnt), 32'(0));
    chk("oor_we",   32'(spad_we), 32'(0));
    chk("oor_addr", 32'(spad_addr), 32'(8'h11));
    tick();
    rd_req = 1'b0;
    mid();
    chk("oor_err",   32'(rd_err), 32'(1));
    chk("oor_valid", 32'(rd_valid), 32'(0));
    tick();
    mid();
    chk("oor_err_clr", 32'(rd_err), 32'(0));
    tick();

    // ---- zero-length burst goes straight to LDONE
    ld_start = 1'b1; ld_base = 8'h30; ld_len = 8'd0;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'h1234;
    mid();
    chk("z_done",  32'(ld_done), 32'(1));
    chk("z_ready", 32'(ld_ready), 32'(0));
    chk("z_we",    32'(spad_we), 32'(0));
    tick();
    ld_valid = 1'b0;
    mid();
    chk("z_idle", 32'(ld_busy), 32'(0));
    tick();

    // ---- write after read: exactly one bubble
    ld_start = 1'b1; ld_base = 8'h40; ld_len = 8'd2;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'h5A5A;
    rd_req = 1'b1; rd_addr = 8'h10;
    mid();
    chk("war_rd",   32'(rd_gnt), 32'(1));
    chk("war_rdy0", 32'(ld_ready), 32'(0));
    tick();
    rd_req = 1'b0;
    mid();
    chk("war_bubble", 32'(ld_ready), 32'(0));
    chk("war_we",     32'(spad_we), 32'(0));
    chk("war_data",   32'(rd_data), 32'(16'hA001));
    tick();
    mid();
    chk("war_wr1",   32'(ld_ready), 32'(1));
    chk("war_addr1", 32'(spad_addr), 32'(8'h40));
    tick();
    mid();
    chk("war_wr2",   32'(ld_ready), 32'(1));
    chk("war_addr2", 32'(spad_addr), 32'(8'h41));
    tick();
    ld_valid = 1'b0;
    mid();
    chk("war_done", 32'(ld_done), 32'(1));
    tick();

    // ---- continuous reads during a load
    ld_start = 1'b1; ld_base = 8'h50; ld_len = 8'd3;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'hC0DE;
    rd_req = 1'b1; rd_addr = 8'h12;
    nw = 0; prev_rd = 1'b0;
    for (int k = 0; k < 6; k++) begin
`ifdef FILTER_SPAD_CTRL_RR_EN
      exp_rd = (k % 3 == 0);
      exp_wr = (k % 3 == 2);
`else
      exp_rd = 1'b1;
      exp_wr = 1'b0;
`endif
      mid();
      chk($sformatf("ct_rd%0d", k),  32'(rd_gnt), 32'(exp_rd));
      chk($sformatf("ct_wr%0d", k),  32'(ld_ready), 32'(exp_wr));
      chk($sformatf("ct_ta%0d", k),  32'(spad_we & prev_rd), 32'(0));
      prev_rd = rd_gnt;
      nw += int'(ld_ready);
      tick();
    end
    rd_req = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      mid();
      if (ld_done) done = 1'b1;
      else begin
        nw += int'(ld_ready);
        tick();
      end
    end
    chk("ct_done",  32'(done), 32'(1));
    chk("ct_words", 32'(nw), 32'(3));
    ld_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) chk($sformatf("ct_mem%0d", i), 32'(mem[8'h50 + i]), 32'(16'hC0DE));

    // ---- reset mid-burst after 2 of 5 words
    ld_start = 1'b1; ld_base = 8'h60; ld_len = 8'd5;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 16'(16'hD001 + i);
      tick();
    end
    ld_valid = 1'b0; rst_n = 1'b0;
    mid();
    chk("mr_in_rst_busy", 32'(ld_busy), 32'(0));
    chk("mr_in_rst_done", 32'(ld_done), 32'(0));
    tick();
    rst_n = 1'b1;
    mid();
    chk("mr_busy", 32'(ld_busy), 32'(0));
    chk("mr_done", 32'(ld_done), 32'(0));
    tick();
    mid();
    chk("mr_done2", 32'(ld_done), 32'(0));
    tick();
    ld_start = 1'b1; ld_base = 8'h70; ld_len = 8'd1;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'hE001;
    mid();
    chk("mr_new_busy", 32'(ld_busy), 32'(1));
    chk("mr_new_rdy",  32'(ld_ready), 32'(1));
    chk("mr_new_addr", 32'(spad_addr), 32'(8'h70));
    tick();
    ld_valid = 1'b0;
    mid();
    chk("mr_new_done", 32'(ld_done), 32'(1));
    tick();
    chk("mr_mem60", 32'(mem[8'h60]), 32'(16'hD001));
    chk("mr_mem61", 32'(mem[8'h61]), 32'(16'hD002));
    chk("mr_mem62", 32'(mem[8'h62]), 32'(16'h0000));
    chk("mr_mem70", 32'(mem[8'h70]), 32'(16'hE001));

    // ---- oversized burst is clamped to DEPTH words
    ld_start = 1'b1; ld_base = 8'h00; ld_len = 8'd250;
    tick();
    ld_start = 1'b0; ld_valid = 1'b1; ld_data = 16'hF00F;
    nw = 0; done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      mid();
      if (ld_done) done = 1'b1;
      else begin
        nw += int'(ld_ready);
        tick();
      end
    end
    chk("cl_done",  32'(done), 32'(1));
    chk("cl_words", 32'(nw), 32'(224));
    ld_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/filter_spad_ctrl.md
FILTER_SPAD_CTRL -- requirements
Module: filter_spad_ctrl

Interface
REQ-001 Parameters SHALL be:
  - DEPTH, 224, number of 16-bit filter-scratchpad words.
  - DATA_W, 16, word width.
REQ-002 Ports SHALL be (name, direction, width, meaning), in this order:
  - clk  in  1  sole clock, rising edge.
  - rst_n  in  1  synchronous, active-low reset.
  - ld_start  in  1  start load burst.
  - ld_base  in  8  burst start address.
  - ld_len  in  8  burst length in words.
  - ld_valid  in  1  load word valid.
  - ld_data  in  16  load word.
  - ld_ready  out  1  load word accepted this cycle.
  - ld_busy  out  1  burst in progress.
  - ld_done  out  1  one-cycle burst-complete pulse.
  - rd_req  in  1  PE read request.
  - rd_addr  in  8  PE read address.
  - rd_gnt  out  1  read accepted this cycle.
  - rd_valid  out  1  read data valid.
  - rd_data  out  16  read data.
  - rd_err  out  1  one-cycle out-of-range pulse.
  - spad_addr  out  8  scratchpad address.
  - spad_we  out  1  scratchpad write enable (1 = write).
  - spad_data  inout  16  scratchpad data bus.

Function
REQ-003 FSM states SHALL be IDLE, LOAD and LDONE.
REQ-004 In IDLE, ld_start SHALL latch ld_base/ld_len and move to LOAD; ld_len = 0 SHALL go directly to LDONE.
REQ-005 In LOAD, each ld_valid & ld_ready cycle SHALL write ld_data at the current pointer, then increment pointer and count.
REQ-006 The pointer SHALL wrap from DEPTH-1 to 0; ld_len > DEPTH SHALL be clamped to DEPTH.
REQ-007 After the final accepted write, the FSM SHALL enter LDONE, assert ld_done for one cycle, then return to IDLE.
REQ-008 ld_busy SHALL be 1 in LOAD and LDONE; ld_start while ld_busy SHALL be ignored.
REQ-009 spad_addr/spad_we SHALL be combinational from the current cycle's grant.
REQ-010 spad_data SHALL be driven with ld_data only when spad_we = 1; otherwise it SHALL be high-Z.
REQ-011 Idle cycles (no grant) SHALL leave spad_we = 0 and spad_addr at its last value.
REQ-012 rd_gnt in cycle N SHALL give rd_valid = 1 in N+1, with rd_data = spad_data sampled in N+1.
REQ-013 rd_gnt SHALL be asserted in any cycle with rd_req & rd_addr < DEPTH, except as REQ-015 and REQ-021 restrict.
REQ-014 rd_req with rd_addr >= DEPTH SHALL get no grant and no spad access; rd_err SHALL pulse in N+1 with rd_valid = 0.
REQ-015 Turnaround: no write grant SHALL occur in the cycle following a read grant, because the spad drives the bus then.
REQ-016 Default arbitration SHALL be fixed priority, reads over writes; ld_ready = LOAD & ld_valid & no read grant & no turnaround block.
REQ-017 Back-to-back reads SHALL be allowed at one per cycle.
REQ-018 Write-after-read SHALL incur exactly one bubble cycle.

Reset
REQ-019 With rst_n = 0 at a rising edge, the block SHALL enter IDLE and clear pointer, count, RR state and turnaround flag.
REQ-020 During and after reset, outputs SHALL be: ld_ready, ld_busy, ld_done, rd_gnt, rd_valid, rd_err, spad_we = 0; spad_addr = 0; rd_data = 0 while rd_valid = 0. A reset mid-burst SHALL abort the burst with no ld_done; scratchpad contents are not cleared.

Configuration
REQ-021 With FILTER_SPAD_CTRL_RR_EN defined, arbitration SHALL be round-robin instead of REQ-016:
  - After a read grant with a write pending, the next cycle SHALL be a bubble (no read or write grant).
  - The cycle after that SHALL grant the write over any read.
  - Without the macro, REQ-016 applies and writes may starve under continuous reads.

Structure
REQ-022 Package filter_spad_pkg SHALL hold SPAD_DEPTH = 224, SPAD_ADDR_W = 8, SPAD_DATA_W = 16 and the FSM state enum.
REQ-023 Grant logic (REQ-015/016/021) SHALL be a sub-module fspad_arb.
REQ-024 Scratchpad storage SHALL NOT be instantiated inside this block; the testbench connects a 224x16 registered-read scratchpad model.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
  - Load base=0x10, len=4, data 0xA001..0xA004, no reads -> ld_ready held 4 cycles, spad[0x10..0x13] written, ld_done one cycle after the last write.
  - Load base=222, len=4 -> addresses 222, 223, 0, 1 written.
  - Reads at 0x10 then 0x11 in consecutive cycles after the load -> rd_valid on the two following cycles with 0xA001 and 0xA002.
  - rd_addr=224 -> no rd_gnt, rd_err pulse next cycle, spad_we stays 0.
  - Continuous rd_req during a load with ld_valid held:
    - Default: ld_ready = 0 throughout.
    - FILTER_SPAD_CTRL_RR_EN: pattern read, bubble, write repeating; no cycle has spad_we = 1 directly after rd_gnt.
  - rst_n = 0 after 2 of 5 words -> ld_busy = 0 next cycle, no ld_done; a new ld_start is then accepted.
